// File: rtl/dpsk_frame_sync.sv
// dpsk_frame_sync: sync-word hunter (polarity-correcting, error-tolerant), length-framed payload parser and commit-on-accept FIFO.
// Optional checksum byte after the payload is enabled by defining DPSK_CHKSUM_EN.
module dpsk_frame_sync #(
    parameter int                SYNC_W     = 16,
    parameter logic [SYNC_W-1:0] SYNC_WORD  = 16'hEB90,
    parameter int                MAX_ERR    = 1,
    parameter int                MAX_LEN    = 64,
    parameter int                FIFO_DEPTH = 128
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       bit_data,
    input  logic       bit_vld,
    output logic [7:0] out_data,
    output logic       out_vld,
    input  logic       out_ready,
    output logic       locked,
    output logic       polarity,
    output logic       frame_ok,
    output logic       frame_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(SYNC_W);
    typedef enum logic [2:0] {HUNT, LEN, PAY, CHK, COMMIT} state_t;
    state_t            r_state;
    logic [SYNC_W-1:0] r_sreg, w_sreg;
    logic [CW-1:0]     r_seen;
    logic [2:0]        r_bcnt;
    logic [7:0]        r_byte, r_cnt, r_sum, w_byte;
    logic [AW:0]       r_wp_t, r_wp_c, r_rp, w_used, w_free;
    logic [7:0]        r_mem [FIFO_DEPTH];
    logic              r_pol, r_locked, r_ok, r_err;
    logic              w_bit, w_done, w_judge, w_mn, w_mi, w_len_bad, w_abort;
    assign w_sreg    = {r_sreg[SYNC_W-2:0], bit_data};
    assign w_judge   = r_seen >= CW'(SYNC_W - 1);
    assign w_mn      = $countones(w_sreg ^ SYNC_WORD) <= MAX_ERR;
    assign w_mi      = $countones(w_sreg ^ ~SYNC_WORD) <= MAX_ERR;
    assign w_bit     = bit_data ^ r_pol;
    assign w_byte    = {r_byte[6:0], w_bit};
    assign w_done    = bit_vld && r_bcnt == 3'd7;
    assign w_used    = r_wp_t - r_rp;
    assign w_free    = (AW+1)'(FIFO_DEPTH) - w_used;
    assign w_len_bad = w_byte == 8'd0 || 32'(w_byte) > MAX_LEN || 32'(w_byte) > 32'(w_free);
    assign w_abort   = w_done && ((r_state == LEN && w_len_bad) || (r_state == CHK && w_byte != r_sum));
    assign out_vld   = r_wp_c != r_rp;
    assign out_data  = r_mem[r_rp[AW-1:0]];
    assign locked    = r_locked;
    assign polarity  = r_pol;
    assign frame_ok  = r_ok;
    assign frame_err = r_err;
    always_ff @(posedge sys_clk)
        if (r_state == PAY && w_done) r_mem[r_wp_t[AW-1:0]] <= w_byte;
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= HUNT;
            r_sreg   <= '0;
            r_seen   <= '0;
            r_bcnt   <= '0;
            r_byte   <= '0;
            r_cnt    <= '0;
            r_sum    <= '0;
            r_wp_t   <= '0;
            r_wp_c   <= '0;
            r_rp     <= '0;
            r_pol    <= 1'b0;
            r_locked <= 1'b0;
            r_ok     <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_ok  <= 1'b0;
            r_err <= 1'b0;
            if (out_vld && out_ready) r_rp <= r_rp + 1'b1;
            if (bit_vld && r_state inside {LEN, PAY, CHK}) begin
                r_bcnt <= r_bcnt + 1'b1;
                r_byte <= w_byte;
            end
            case (r_state)
                HUNT: if (bit_vld) begin
                    r_sreg <= w_sreg;
                    r_seen <= w_judge ? r_seen : r_seen + 1'b1;
                    if (w_judge && (w_mn || w_mi)) begin
                        r_pol    <= !w_mn;
                        r_locked <= 1'b1;
                        r_state  <= LEN;
                    end
                end
                LEN: if (w_done && !w_len_bad) begin
                    r_cnt   <= w_byte;
                    r_sum   <= 8'd0;
                    r_state <= PAY;
                end
                PAY: if (w_done) begin
                    r_wp_t <= r_wp_t + 1'b1;
                    r_sum  <= r_sum + w_byte;
                    r_cnt  <= r_cnt - 8'd1;
`ifdef DPSK_CHKSUM_EN
                    if (r_cnt == 8'd1) r_state <= CHK;
`else
                    if (r_cnt == 8'd1) r_state <= COMMIT;
`endif
                end
                CHK: if (w_done && w_byte == r_sum) r_state <= COMMIT;
                default: begin
                    // a bit arriving now is the first bit of the next hunt
                    r_wp_c   <= r_wp_t;
                    r_ok     <= 1'b1;
                    r_locked <= 1'b0;
                    r_state  <= HUNT;
                    r_sreg   <= bit_vld ? {{(SYNC_W-1){1'b0}}, bit_data} : '0;
                    r_seen   <= bit_vld ? CW'(1) : '0;
                end
            endcase
            if (w_abort) begin
                r_wp_t   <= r_wp_c;
                r_err    <= 1'b1;
                r_locked <= 1'b0;
                r_sreg   <= '0;
                r_seen   <= '0;
                r_state  <= HUNT;
            end
        end
    end
endmodule
